// File: rtl/register_file.sv
// register_file: 2**ADDR x N general-purpose register file.
//   Two combinational read ports (0-cycle latency), one synchronous write port.
//   Register 0 is hardwired to zero and has no storage; writes to it are dropped.
// Ports:
//   clk                rising-edge clock
//   rst                asynchronous, active-low reset; clears every register
//   wr_ena             write enable, gates the write-address decoder tree
//   wr_addr, wr_data   destination index and data, captured on rising clk
//   rd_addr0/rd_data0  read port 0 (rs1), combinational
//   rd_addr1/rd_data1  read port 1 (rs2), combinational
// No read-during-write bypass: a read of the register being written returns
// the old value until the edge. Writeback forwarding belongs to the pipeline.

// decoder_1_to_2: one address bit to two one-hot enables, gated by en.
//   Ports: en (enable), sel (address bit), y (one-hot outputs, all zero when en=0).
module decoder_1_to_2 (
  input  logic       en,
  input  logic       sel,
  output logic [1:0] y
);
  assign y[0] = en & ~sel;
  assign y[1] = en &  sel;
endmodule

// decoder_2_to_4: two address bits to four one-hot enables, gated by en.
//   Ports: en (enable), sel (address bits), y (one-hot outputs, all zero when en=0).
module decoder_2_to_4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);
  assign y[0] = en & ~sel[1] & ~sel[0];
  assign y[1] = en & ~sel[1] &  sel[0];
  assign y[2] = en &  sel[1] & ~sel[0];
  assign y[3] = en &  sel[1] &  sel[0];
endmodule

module register_file #(
  parameter int N    = 32,
  parameter int ADDR = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ena,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [N-1:0]    wr_data,
  input  logic [ADDR-1:0] rd_addr0,
  output logic [N-1:0]    rd_data0,
  input  logic [ADDR-1:0] rd_addr1,
  output logic [N-1:0]    rd_data1
);

  localparam int DEPTH = 1 << ADDR;

  // Decoder tree shape: an odd address width is handled by a 1-to-2 stage on
  // the MSB, then each further pair of bits (MSB first) fans every enable out
  // through a 2-to-4 decoder. Stage k therefore has W0 * 4**k enables.
  localparam int ODD = ADDR % 2;
  localparam int NQ  = ADDR / 2;
  localparam int W0  = 1 << ODD;

  // Bit offset of stage k inside the flat 'tree' vector holding all stages.
  function automatic int lvl_off(input int k);
    int o;
    int w;
    o = 0;
    w = W0;
    for (int i = 0; i < k; i++) begin
      o += w;
      w *= 4;
    end
    return o;
  endfunction

  localparam int TREE_W = lvl_off(NQ + 1);

  logic [TREE_W-1:0] tree;
  logic [DEPTH-1:0]  wr_sel;

  if (ODD == 1) begin : g_pre
    decoder_1_to_2 u_dec (
      .en  (wr_ena),
      .sel (wr_addr[ADDR-1]),
      .y   (tree[1:0])
    );
  end else begin : g_pre
    assign tree[0] = wr_ena;
  end

  for (genvar k = 1; k <= NQ; k++) begin : g_stage
    localparam int WI  = W0 << (2 * (k - 1));
    localparam int OI  = lvl_off(k - 1);
    localparam int OO  = lvl_off(k);
    localparam int LSB = ADDR - ODD - 2 * k;
    // Node j of the previous stage owns enables 4j..4j+3 of this stage, so the
    // final stage index equals the full write address.
    for (genvar j = 0; j < WI; j++) begin : g_node
      decoder_2_to_4 u_dec (
        .en  (tree[OI + j]),
        .sel (wr_addr[LSB+1:LSB]),
        .y   (tree[OO + 4*j +: 4])
      );
    end
  end

  assign wr_sel = tree[lvl_off(NQ) +: DEPTH];

  // The decoder must never select more than one register. Simulation-only
  // check; synthesis ignores it. Bit 0 (x0) is decoded but drives no storage.
  a_wr_sel_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(wr_sel));

  // Storage for x1..x(DEPTH-1) only; x0 has no flop.
  logic [N-1:0] regs [1:DEPTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Read muxes: index 0 falls through to the zero default.
  always_comb begin
    rd_data0 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (rd_addr0 == ADDR'(i)) begin
        rd_data0 = regs[i];
      end
    end
  end

  always_comb begin
    rd_data1 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (rd_addr1 == ADDR'(i)) begin
        rd_data1 = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/100ps
module tb_register_file;

  localparam int N     = 32;
  localparam int ADDR  = 5;
  localparam int DEPTH = 1 << ADDR;

  logic            clk      = 1'b0;
  logic            rst      = 1'b0;
  logic            wr_ena   = 1'b0;
  logic [ADDR-1:0] wr_addr  = '0;
  logic [N-1:0]    wr_data  = '0;
  logic [ADDR-1:0] rd_addr0 = '0;
  logic [ADDR-1:0] rd_addr1 = '0;
  logic [N-1:0]    rd_data0;
  logic [N-1:0]    rd_data1;

  int vectors     = 0;
  int miscompares = 0;

  // Architectural model: one word per register, x0 never written.
  logic [N-1:0] mdl [DEPTH];

  register_file #(.N(N), .ADDR(ADDR)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_rd(input logic [ADDR-1:0] a);
    return (a == '0) ? '0 : mdl[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  initial model_clear();

  always @(negedge rst) model_clear();

  always @(posedge clk) begin
    if (rst !== 1'b1) model_clear();
    else if (wr_ena === 1'b1 && wr_addr != '0) mdl[wr_addr] = wr_data;
  end

  always @(posedge clk) begin
    if (rst === 1'b1 && $isunknown(wr_ena)) begin
      miscompares++;
      $display("FAIL wr_ena_known at %0t: got %b, expected 0 or 1", $time, wr_ena);
    end
  end

  // Every-cycle comparison of both read ports against the model.
  always @(negedge clk) begin
    check("port0_model", rd_data0, model_rd(rd_addr0));
    check("port1_model", rd_data1, model_rd(rd_addr1));
  end

  task automatic drive(input logic ena, input logic [ADDR-1:0] wa, input logic [N-1:0] wd,
                       input logic [ADDR-1:0] ra0, input logic [ADDR-1:0] ra1);
    wr_ena   = ena;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr0 = ra0;
    rd_addr1 = ra1;
  endtask

  // One rising edge, then land mid-low-phase where inputs may change.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) tick();
    drive(1'b0, 5'd0, '0, 5'd5, 5'd31);
    #1;
    check("reset_rd0", rd_data0, 32'h0);
    check("reset_rd1", rd_data1, 32'h0);
    rst = 1'b1;
    tick();

    // Write then read back; neighbour stays zero.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
    #1;
    check("wr5_before_edge", rd_data0, 32'h0);
    tick();
    check("wr5_readback", rd_data0, 32'hDEADBEEF);
    check("wr5_neighbour", rd_data1, 32'h0);

    // x0 guard.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    tick();
    check("x0_port0", rd_data0, 32'h0);
    check("x0_port1", rd_data1, 32'h0);
    drive(1'b0, 5'd0, '0, 5'd5, 5'd5);
    #1;
    check("x0_no_alias", rd_data1, 32'hDEADBEEF);

    // Disabled writes, including X address/data.
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    tick();
    drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
    repeat (3) tick();
    check("disabled_wr7", rd_data0, 32'h12345678);
    drive(1'b0, 'x, 'x, 5'd7, 5'd5);
    repeat (2) tick();
    check("x_inputs_rd7", rd_data0, 32'h12345678);
    check("x_inputs_rd5", rd_data1, 32'hDEADBEEF);

    // Read-during-write: old value before the edge, new value after.
    drive(1'b1, 5'd9, 32'hA, 5'd9, 5'd9);
    tick();
    drive(1'b1, 5'd9, 32'hB, 5'd9, 5'd9);
    #1;
    check("rdw_before_p0", rd_data0, 32'hA);
    check("rdw_before_p1", rd_data1, 32'hA);
    tick();
    check("rdw_after", rd_data0, 32'hB);

    // Fill every register with a distinct value.
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b1, ADDR'(i), (32'(i) * 32'h01010101) ^ 32'h5A5A0000, ADDR'(i), 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, '0, 5'd31, 5'd1);
    #1;
    check("fill_31", rd_data0, 32'h1F1F1F1F ^ 32'h5A5A0000);
    check("fill_1", rd_data1, 32'h01010101 ^ 32'h5A5A0000);

    // Asynchronous reset: all 32 addresses read zero with no clock edge.
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr0 = ADDR'(a);
      rd_addr1 = ADDR'(DEPTH - 1 - a);
      #0.1;
      check("async_reset_p0", rd_data0, 32'h0);
      check("async_reset_p1", rd_data1, 32'h0);
    end
    tick();
    rst = 1'b1;
    tick();

    // Reset falling with a write pending aborts the write.
    drive(1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(1'b0, 5'd0, '0, 5'd3, 5'd3);
    tick();
    check("reset_aborts_write", rd_data0, 32'h0);

    // Random traffic, checked every cycle by the compare process.
    for (int it = 0; it < 100; it++) begin
      drive(1'($urandom_range(0, 1)), ADDR'($urandom_range(0, DEPTH - 1)), $urandom,
            ADDR'($urandom_range(0, DEPTH - 1)), ADDR'($urandom_range(0, DEPTH - 1)));
      tick();
    end
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $fatal(1, "register file disagreed with the model");
    $finish;
  end

endmodule
